// File: rtl/ctrl_unit_if.sv
// ctrl_unit_if: memory and ALU bus of the 8-bit accumulator computer.
//   master (ctrl_unit): drives mem_addr, mem_we, mem_wdata and the ALU
//                       operands/control; receives mem_rdata, alu_result.
//   slave  (memory/ALU side): the mirror image.
//   mem_rdata is valid the cycle after mem_addr is presented.
interface ctrl_unit_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [1:0] alu_ctrl;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_pc;
  logic [7:0] alu_result;

  modport master (
    output mem_addr, mem_we, mem_wdata, alu_ctrl, alu_a, alu_b, alu_pc,
    input  mem_rdata, alu_result
  );

  modport slave (
    input  mem_addr, mem_we, mem_wdata, alu_ctrl, alu_a, alu_b, alu_pc,
    output mem_rdata, alu_result
  );
endinterface

// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle control FSM of the 8-bit accumulator computer.
// Owns PC, ACC, IR and OPR; fetches two-byte instructions (one byte for HLT)
// from synchronous-read memory and uses the external combinational ALU for
// ADD/NAND/SLT and the BZ target select.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   run        - start/continue, sampled only in FETCH
//   bus        - ctrl_unit_if.master: memory and ALU signals
//   pc, acc    - registered program counter / accumulator
//   halted     - high from HLT decode until reset
//   instr_done - one-cycle pulse on re-entry to FETCH after an instruction
module ctrl_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  ctrl_unit_if.master bus,
  output logic [7:0]  pc,
  output logic [7:0]  acc,
  output logic        halted,
  output logic        instr_done
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPND, S_OPLAT, S_MEM, S_EXEC, S_HALT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_SLT  = 3'd2;
  localparam logic [2:0] OP_BZ   = 3'd3;
  localparam logic [2:0] OP_LDA  = 3'd4;
  localparam logic [2:0] OP_STA  = 3'd5;
  localparam logic [2:0] OP_LDI  = 3'd6;
  localparam logic [2:0] OP_HLT  = 3'd7;

  state_t     state_q;
  logic [7:0] pc_q;
  logic [7:0] acc_q;
  // Only the opcode field of the instruction byte is kept; bits [7:3] are
  // architecturally ignored.
  logic [2:0] ir_q;
  logic [7:0] opr_q;
  logic       halted_q;
  logic       instr_done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      acc_q        <= 8'h00;
      ir_q         <= 3'd0;
      opr_q        <= 8'h00;
      halted_q     <= 1'b0;
      instr_done_q <= 1'b0;
    end else begin
      instr_done_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (run) state_q <= S_DECODE;
        end
        S_DECODE: begin
          ir_q <= bus.mem_rdata[2:0];
          pc_q <= pc_q + 8'd1;
          if (bus.mem_rdata[2:0] == OP_HLT) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_OPND;
          end
        end
        S_OPND: state_q <= S_OPLAT;
        S_OPLAT: begin
          opr_q <= bus.mem_rdata;
          case (ir_q)
            // ALU returns A when ACC==0, else PC+1 (PC points at the operand).
            OP_BZ: begin
              pc_q         <= bus.alu_result;
              state_q      <= S_FETCH;
              instr_done_q <= 1'b1;
            end
            OP_LDI: begin
              acc_q        <= bus.mem_rdata;
              pc_q         <= pc_q + 8'd1;
              state_q      <= S_FETCH;
              instr_done_q <= 1'b1;
            end
            default: begin
              pc_q    <= pc_q + 8'd1;
              state_q <= S_MEM;
            end
          endcase
        end
        S_MEM: begin
          if (ir_q == OP_STA) begin
            state_q      <= S_FETCH;
            instr_done_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Only ADD/NAND/SLT/LDA reach EXEC.
          if (ir_q == OP_LDA) acc_q <= bus.mem_rdata;
          else                acc_q <= bus.alu_result;
          state_q      <= S_FETCH;
          instr_done_q <= 1'b1;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    bus.mem_addr = pc_q;
    if (state_q == S_MEM || state_q == S_EXEC) bus.mem_addr = opr_q;
  end

  // Gated with rst_n so a reset asserted during MEM suppresses the store
  // at the same edge.
  assign bus.mem_we    = rst_n && (state_q == S_MEM) && (ir_q == OP_STA);
  assign bus.mem_wdata = acc_q;

  always_comb begin
    bus.alu_ctrl = 2'b00;
    if (state_q == S_EXEC) begin
      case (ir_q)
        OP_NAND: bus.alu_ctrl = 2'b01;
        OP_SLT:  bus.alu_ctrl = 2'b11;
        default: bus.alu_ctrl = 2'b00;
      endcase
    end else if (state_q == S_OPLAT && ir_q == OP_BZ) begin
      bus.alu_ctrl = 2'b10;
    end
  end

  assign bus.alu_a  = acc_q;
  assign bus.alu_b  = bus.mem_rdata;
  assign bus.alu_pc = pc_q;

  assign pc         = pc_q;
  assign acc        = acc_q;
  assign halted     = halted_q;
  assign instr_done = instr_done_q;

endmodule

// File: tb/tb_ctrl_unit.sv
module tb_ctrl_unit;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [7:0] pc;
  logic [7:0] acc;
  logic       halted;
  logic       instr_done;

  ctrl_unit_if bus();

  ctrl_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .bus        (bus.master),
    .pc         (pc),
    .acc        (acc),
    .halted     (halted),
    .instr_done (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory seen by the DUT.
  logic [7:0] dut_mem [256];
  always @(posedge clk) begin
    bus.mem_rdata <= dut_mem[bus.mem_addr];
    if (bus.mem_we) dut_mem[bus.mem_addr] = bus.mem_wdata;
  end

  // External ALU.
  always_comb begin
    case (bus.alu_ctrl)
      2'b00:   bus.alu_result = bus.alu_a + bus.alu_b;
      2'b01:   bus.alu_result = ~(bus.alu_a & bus.alu_b);
      2'b11:   bus.alu_result = (bus.alu_a < bus.alu_b) ? 8'h01 : 8'h00;
      default: bus.alu_result = (bus.alu_a == 8'h00) ? bus.alu_b : bus.alu_pc + 8'h01;
    endcase
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction-level reference model.
  logic [7:0]  ref_mem [256];
  logic [7:0]  m_acc, m_pc;
  int          m_cyc;
  bit          m_halt;
  logic [7:0]  m_acc_tr[$], m_pc_tr[$], d_acc_tr[$], d_pc_tr[$];
  logic [15:0] m_st[$], d_st[$];

  task automatic model_run(input int max_instr);
    logic [2:0] op;
    logic [7:0] a;
    m_pc = RESET_PC; m_acc = 8'h00; m_cyc = 0; m_halt = 0;
    m_acc_tr.delete(); m_pc_tr.delete(); m_st.delete();
    for (int i = 0; i < max_instr && !m_halt; i++) begin
      op = ref_mem[m_pc][2:0];
      a  = ref_mem[m_pc + 8'd1];
      case (op)
        3'd0: begin m_acc = m_acc + ref_mem[a];                m_pc = m_pc + 8'd2; m_cyc += 6; end
        3'd1: begin m_acc = ~(m_acc & ref_mem[a]);             m_pc = m_pc + 8'd2; m_cyc += 6; end
        3'd2: begin m_acc = (m_acc < ref_mem[a]) ? 8'd1 : 8'd0; m_pc = m_pc + 8'd2; m_cyc += 6; end
        3'd3: begin m_pc = (m_acc == 8'h00) ? a : m_pc + 8'd2;  m_cyc += 4; end
        3'd4: begin m_acc = ref_mem[a];                        m_pc = m_pc + 8'd2; m_cyc += 6; end
        3'd5: begin ref_mem[a] = m_acc; m_st.push_back({a, m_acc}); m_pc = m_pc + 8'd2; m_cyc += 5; end
        3'd6: begin m_acc = a;                                 m_pc = m_pc + 8'd2; m_cyc += 4; end
        default: begin m_pc = m_pc + 8'd1; m_cyc += 2; m_halt = 1; end
      endcase
      if (!m_halt) begin
        m_acc_tr.push_back(m_acc);
        m_pc_tr.push_back(m_pc);
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin dut_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
  endtask

  task automatic put(input logic [7:0] addr, input logic [7:0] data);
    dut_mem[addr] = data;
    ref_mem[addr] = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    chk("rst.pc",       32'(pc),           32'(RESET_PC));
    chk("rst.acc",      32'(acc),          32'h0);
    chk("rst.halted",   32'(halted),       32'h0);
    chk("rst.done",     32'(instr_done),   32'h0);
    chk("rst.mem_we",   32'(bus.mem_we),   32'h0);
    chk("rst.mem_addr", 32'(bus.mem_addr), 32'(RESET_PC));
  endtask

  task automatic run_prog(input string name, input int max_instr);
    int nmis;
    model_run(max_instr);
    d_acc_tr.delete(); d_pc_tr.delete(); d_st.delete();
    do_reset();
    rst_n = 1'b1;
    run   = 1'b1;
    for (int k = 1; k <= m_cyc; k++) begin
      @(negedge clk);
      if (instr_done) begin d_acc_tr.push_back(acc); d_pc_tr.push_back(pc); end
      if (bus.mem_we) d_st.push_back({bus.mem_addr, bus.mem_wdata});
      if (m_halt && k == m_cyc - 1) chk({name, ".pre_halt"}, 32'(halted), 32'h0);
    end
    chk({name, ".ndone"}, 32'(d_acc_tr.size()), 32'(m_acc_tr.size()));
    for (int i = 0; i < m_acc_tr.size() && i < d_acc_tr.size(); i++) begin
      chk($sformatf("%s.acc_tr%0d", name, i), 32'(d_acc_tr[i]), 32'(m_acc_tr[i]));
      chk($sformatf("%s.pc_tr%0d", name, i),  32'(d_pc_tr[i]),  32'(m_pc_tr[i]));
    end
    chk({name, ".nstore"}, 32'(d_st.size()), 32'(m_st.size()));
    for (int i = 0; i < m_st.size() && i < d_st.size(); i++)
      chk($sformatf("%s.store%0d", name, i), 32'(d_st[i]), 32'(m_st[i]));
    chk({name, ".pc"},     32'(pc),     32'(m_pc));
    chk({name, ".acc"},    32'(acc),    32'(m_acc));
    chk({name, ".halted"}, 32'(halted), 32'(m_halt));
    nmis = 0;
    for (int i = 0; i < 256; i++) if (dut_mem[i] !== ref_mem[i]) nmis++;
    chk({name, ".mem"}, 32'(nmis), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;

    // Pause: run=0 holds FETCH.
    clear_mem();
    put(8'h00, 8'h06); put(8'h01, 8'h05);
    do_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold.pc",       32'(pc),           32'h0);
      chk("hold.mem_addr", 32'(bus.mem_addr), 32'h0);
      chk("hold.mem_we",   32'(bus.mem_we),   32'h0);
      chk("hold.done",     32'(instr_done),   32'h0);
    end

    // LDI 5, ADD [0x10], HLT.
    clear_mem();
    put(8'h00, 8'h06); put(8'h01, 8'h05); put(8'h02, 8'h00); put(8'h03, 8'h10);
    put(8'h04, 8'h07); put(8'h10, 8'h03);
    run_prog("progA", 10);
    chk("progA.acc_c",   32'(acc),             32'h08);
    chk("progA.pc_c",    32'(pc),              32'h05);
    chk("progA.ndone_c", 32'(d_acc_tr.size()), 32'd2);
    // HALT ignores run and freezes state.
    for (int k = 0; k < 3; k++) begin
      run = k[0];
      @(negedge clk);
    end
    chk("halt.pc",     32'(pc),         32'h05);
    chk("halt.acc",    32'(acc),        32'h08);
    chk("halt.halted", 32'(halted),     32'h1);
    chk("halt.mem_we", 32'(bus.mem_we), 32'h0);
    chk("halt.done",   32'(instr_done), 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("halt_rst.halted", 32'(halted), 32'h0);
    chk("halt_rst.pc",     32'(pc),     32'h0);
    rst_n = 1'b1;

    // BZ taken.
    clear_mem();
    put(8'h00, 8'h06); put(8'h01, 8'h00); put(8'h02, 8'h03); put(8'h03, 8'h20);
    put(8'h20, 8'h07);
    run_prog("bz_taken", 10);
    chk("bz_taken.pc_bz", 32'(d_pc_tr.size() > 1 ? d_pc_tr[1] : 8'hxx), 32'h20);
    chk("bz_taken.pc_c",  32'(pc), 32'h21);

    // BZ not taken.
    clear_mem();
    put(8'h00, 8'h06); put(8'h01, 8'h01); put(8'h02, 8'h03); put(8'h03, 8'h20);
    put(8'h04, 8'h07); put(8'h20, 8'h07);
    run_prog("bz_fall", 10);
    chk("bz_fall.pc_bz", 32'(d_pc_tr.size() > 1 ? d_pc_tr[1] : 8'hxx), 32'h04);

    // STA/LDA round trip.
    clear_mem();
    put(8'h00, 8'h06); put(8'h01, 8'hA5); put(8'h02, 8'h05); put(8'h03, 8'h80);
    put(8'h04, 8'h06); put(8'h05, 8'h00); put(8'h06, 8'h04); put(8'h07, 8'h80);
    put(8'h08, 8'h07);
    run_prog("stalda", 10);
    chk("stalda.store_c", 32'(d_st.size() > 0 ? d_st[0] : 16'hxxxx), 32'h80A5);
    chk("stalda.acc_c",   32'(acc), 32'hA5);

    // NAND / SLT both ways / ADD overflow.
    clear_mem();
    put(8'h00, 8'h06); put(8'h01, 8'hF0); put(8'h02, 8'h01); put(8'h03, 8'h40);
    put(8'h04, 8'h06); put(8'h05, 8'h03); put(8'h06, 8'h02); put(8'h07, 8'h41);
    put(8'h08, 8'h06); put(8'h09, 8'h80); put(8'h0A, 8'h02); put(8'h0B, 8'h42);
    put(8'h0C, 8'h06); put(8'h0D, 8'hFF); put(8'h0E, 8'h00); put(8'h0F, 8'h43);
    put(8'h10, 8'h07);
    put(8'h40, 8'h3C); put(8'h41, 8'h80); put(8'h42, 8'h03); put(8'h43, 8'h01);
    run_prog("alu", 20);
    chk("alu.nand", 32'(d_acc_tr.size() > 7 ? d_acc_tr[1] : 8'hxx), 32'hCF);
    chk("alu.slt1", 32'(d_acc_tr.size() > 7 ? d_acc_tr[3] : 8'hxx), 32'h01);
    chk("alu.slt0", 32'(d_acc_tr.size() > 7 ? d_acc_tr[5] : 8'hxx), 32'h00);
    chk("alu.ovf",  32'(d_acc_tr.size() > 7 ? d_acc_tr[7] : 8'hxx), 32'h00);

    // Operand fetch wraps from 0xFF to 0x00.
    clear_mem();
    put(8'h00, 8'h03); put(8'h01, 8'hFF); put(8'hFF, 8'h06);
    run_prog("wrap", 10);
    chk("wrap.acc_c", 32'(acc), 32'h03);
    chk("wrap.pc_c",  32'(pc),  32'h02);

    // run dropped after the ADD starts: it still completes in 6 cycles.
    clear_mem();
    put(8'h00, 8'h00); put(8'h01, 8'h10); put(8'h02, 8'h07); put(8'h10, 8'h03);
    do_reset();
    rst_n = 1'b1;
    run   = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) chk("midrun.done5", 32'(instr_done), 32'h0);
    end
    chk("midrun.done6", 32'(instr_done), 32'h1);
    chk("midrun.acc",   32'(acc),        32'h03);
    chk("midrun.pc",    32'(pc),         32'h02);
    @(negedge clk);
    chk("midrun.done7", 32'(instr_done),   32'h0);
    chk("midrun.hold",  32'(bus.mem_addr), 32'h02);

    // Reset asserted in MEM of a STA: no write.
    clear_mem();
    put(8'h00, 8'h06); put(8'h01, 8'hA5); put(8'h02, 8'h05); put(8'h03, 8'h80);
    put(8'h80, 8'h11);
    do_reset();
    rst_n = 1'b1;
    run   = 1'b1;
    for (int k = 1; k <= 8; k++) @(negedge clk);
    chk("starst.we_pre",  32'(bus.mem_we),    32'h1);
    chk("starst.addr",    32'(bus.mem_addr),  32'h80);
    chk("starst.wdata",   32'(bus.mem_wdata), 32'hA5);
    rst_n = 1'b0;
    #1;
    chk("starst.we_gate", 32'(bus.mem_we), 32'h0);
    @(negedge clk);
    chk("starst.mem",  32'(dut_mem[8'h80]), 32'h11);
    chk("starst.pc",   32'(pc),             32'h00);
    chk("starst.acc",  32'(acc),            32'h00);
    chk("starst.addr0", 32'(bus.mem_addr),  32'h00);
    rst_n = 1'b1;

    // Random programs against the instruction-level model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 256; i++) put(8'(i), 8'($urandom));
      run_prog($sformatf("rnd%0d", r), 30);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Multi-cycle sequencer for the 8-bit accumulator computer. It owns PC, ACC and the instruction registers, fetches two-byte instructions from a synchronous-read memory, and drives the shared combinational `alu` for ADD/NAND/SLT/branch. It sits between program/data memory and `alu` as the top-level control FSM of the CPU.

## Interface
- `RESET_PC`, default 8'h00: PC value loaded on reset.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `run` input 1: sampled only in FETCH; 0 holds the FSM in FETCH (single-step/pause).
- `mem_addr` output 8: memory address (combinational from state/registers).
- `mem_rdata` input 8: memory read data, valid the cycle after `mem_addr` is presented.
- `mem_we` output 1: write strobe, one cycle.
- `mem_wdata` output 8: write data, equal to ACC.
- `alu_ctrl` output 2: to `alu.control`.
- `alu_a` output 8: to `alu.dataInACC`, equal to ACC.
- `alu_b` output 8: to `alu.dataIn`, equal to `mem_rdata`.
- `alu_pc` output 8: to `alu.pc`, equal to PC.
- `alu_result` input 8: from `alu.dataOut`.
- `pc` output 8: program counter (registered).
- `acc` output 8: accumulator (registered).
- `halted` output 1: high from HLT decode until reset.
- `instr_done` output 1: one-cycle pulse on the cycle the FSM re-enters FETCH after completing an instruction.

## Operation
- Instruction: byte 0 is the opcode (bits [2:0]; bits [7:3] ignored). Byte 1 is operand A, an address or an immediate. HLT is a single byte.
- Opcodes:
  - 0 ADD: ACC = ACC + M[A]
  - 1 NAND: ACC = ~(ACC & M[A])
  - 2 SLT: ACC = (ACC < M[A]) ? 1 : 0, unsigned
  - 3 BZ: if ACC == 0 then PC = A, else fall through
  - 4 LDA: ACC = M[A]
  - 5 STA: M[A] = ACC
  - 6 LDI: ACC = A
  - 7 HLT
- `alu_ctrl` is driven as 00/01/11 for ADD/NAND/SLT in EXEC, 10 in OPLAT for BZ, and 00 otherwise.
- FSM states:
  - FETCH: `mem_addr`=PC. If `run`, go to DECODE; else stay.
  - DECODE: IR <= `mem_rdata`; PC <= PC+1. If HLT, go to HALT; else go to OPND.
  - OPND: `mem_addr`=PC; go to OPLAT.
  - OPLAT: OPR <= `mem_rdata`.
    - BZ: PC <= `alu_result`, which the ALU returns as PC+1 when ACC≠0 and as A when ACC=0. Go to FETCH.
    - LDI: ACC <= `mem_rdata`; PC <= PC+1; go to FETCH.
    - Others: PC <= PC+1; go to MEM.
  - MEM: `mem_addr`=OPR.
    - STA: `mem_we`=1, `mem_wdata`=ACC; go to FETCH.
    - Others: go to EXEC.
  - EXEC: ADD/NAND/SLT load ACC <= `alu_result`; LDA loads ACC <= `mem_rdata`. Go to FETCH.
  - HALT: terminal; `halted`=1; `mem_we`=0; PC/ACC frozen; `run` ignored.
- `mem_addr` is PC in FETCH, DECODE, OPND and OPLAT; OPR in MEM and EXEC; PC in HALT.
- Arithmetic is 8-bit with carry discarded. ADD 0xFF+0x01 = 0x00.
- PC wraps: 0xFF+1 = 0x00. An opcode at 0xFF takes its operand from 0x00.

## Timing
- Reset (`rst_n`=0 at a rising edge): PC=`RESET_PC`, ACC=0, IR=0, OPR=0, state=FETCH, `halted`=0, `instr_done`=0. Combinational outputs then give `mem_we`=0 and `mem_addr`=`RESET_PC`.
- Reset has priority in every state, including mid-instruction and HALT. A partial instruction is abandoned; a STA interrupted before MEM writes nothing.
- Latency from the first FETCH with `run`=1 back to FETCH:
  - ADD/NAND/SLT/LDA: 6 cycles
  - STA: 5 cycles
  - BZ/LDI: 4 cycles
  - HLT: 2 cycles to HALT
- `instr_done` is asserted in the cycle after the final state of the instruction, coincident with FETCH. It is never asserted for HLT.
- `mem_we` is high for exactly one cycle per STA, in MEM. It is never high in any other state.
- `run` is ignored outside FETCH: once started, an instruction always completes.

## Test plan
- Reset then `run`=1 with memory {00:06 01:05 02:00 03:10 04:07, 10:03}: LDI 5, ADD [0x10], HLT. Required: ACC=0x08; `halted`=1 at cycle 13; PC=0x05; `instr_done` pulses twice.
- BZ, memory {00:06 01:00 02:03 03:20, 20:07}: ACC=0, so PC=0x20 after BZ, then halt at PC=0x21. Repeat with LDI 1: PC=0x04 after BZ.
- STA/LDA round trip: LDI 0xA5, STA 0x80, LDI 0, LDA 0x80. Required: `mem_we` high for exactly one cycle with `mem_addr`=0x80 and `mem_wdata`=0xA5; final ACC=0xA5.
- NAND/SLT/overflow: ACC=0xF0 NAND M=0x3C gives 0xCF; ACC=0x03 SLT M=0x80 gives 0x01; ACC=0x80 SLT M=0x03 gives 0x00; ACC=0xFF ADD M=0x01 gives 0x00.
- `run`=0 for 5 cycles after reset: state stays FETCH, PC=0, no `mem_we`. Deassert `run` mid-ADD: the instruction still completes in 6 cycles.
- Drive `rst_n`=0 in MEM of a STA: no write occurs; next cycle PC=0, ACC=0, state FETCH. Reset from HALT clears `halted`. A program at 0xFF wraps its operand fetch to 0x00.
